// File: rtl/seq_div8_if.sv
// Start/busy/done handshake and operand/result bus between the control unit and seq_div8.
interface seq_div8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div8.sv
// Sequential restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro SEQ_DIV_DBZ_EN: zero divisor short-circuits IDLE -> DONE and raises div_by_zero.
module seq_div8 #(
    parameter int WIDTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    seq_div8_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_last;
    logic             w_zero_dvs;

    // The restored partial remainder is always below the divisor, so its
    // extra (WIDTH+1)-th bit is always 0 and is not stored.
    assign w_shifted  = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_shifted + ~{1'b0, r_dvs} + {{WIDTH{1'b0}}, 1'b1};
    assign w_fits     = ~w_diff[WIDTH];
    assign w_q_nxt    = {r_q[WIDTH-2:0], w_fits};
    assign w_rem_nxt  = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_last     = (r_cnt == LAST);
    assign w_zero_dvs = (bus.divisor == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef SEQ_DIV_DBZ_EN
                    w_next = w_zero_dvs ? S_DONE : S_RUN;
`else
                    w_next = S_RUN;
`endif
                end
            end
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef SEQ_DIV_DBZ_EN
    logic r_dbz;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_remo <= '0;
`ifdef SEQ_DIV_DBZ_EN
            r_dbz  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_q   <= bus.dividend;
                        r_rem <= '0;
                        r_dvs <= bus.divisor;
                        r_cnt <= '0;
`ifdef SEQ_DIV_DBZ_EN
                        if (w_zero_dvs) begin
                            r_quot <= '1;
                            r_remo <= bus.dividend;
                            r_dbz  <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // Publish this step's results directly; the working regs lag by one edge.
                    if (w_last) begin
                        r_quot <= w_q_nxt;
                        r_remo <= w_rem_nxt;
`ifdef SEQ_DIV_DBZ_EN
                        r_dbz  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
`ifdef SEQ_DIV_DBZ_EN
    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    // Never both high: busy and done decode distinct states.
    always_comb
        assert (!(i_rst_n && bus.busy && bus.done));
endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: cycle-count/arithmetic model plus directed literal cases.
module tb_seq_div8;
    localparam int W = 8;
`ifdef SEQ_DIV_DBZ_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div8_if #(.WIDTH(W)) bus ();
    seq_div8 #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: which cycle of the operation we are in, and the arithmetic result.
    bit          m_act = 1'b0;
    int          m_t = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
    logic        m_dbz = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0; m_t = 0; m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act = 1'b1; m_t = 0; m_a = bus.dividend; m_b = bus.divisor;
                if (DBZ && m_b == 0) begin
                    m_t = W; m_q = '1; m_r = m_a; m_dbz = 1'b1;
                end
            end
        end else begin
            m_t++;
            if (m_t == W) begin
                if (m_b == 0) begin m_q = '1; m_r = m_a; end
                else begin m_q = m_a / m_b; m_r = m_a % m_b; end
                m_dbz = 1'b0;
            end else if (m_t == W + 1) begin
                m_act = 1'b0;
            end
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon busy", 32'(bus.busy), 32'(m_act && m_t < W));
            chk("mon done", 32'(bus.done), 32'(m_act && m_t == W));
            chk("mon quotient", 32'(bus.quotient), 32'(m_q));
            chk("mon remainder", 32'(bus.remainder), 32'(m_r));
            chk("mon dbz", 32'(bus.div_by_zero), 32'(m_dbz));
            chk("mon busy&done", 32'(bus.busy & bus.done), 32'd0);
        end
    end

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int elat, input int ebusy, input logic edbz, input string nm);
        int n;
        int nb;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.busy) nb++;
            if (bus.done) seen = 1'b1;
        end
        chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " busy cycles"}, 32'(nb), 32'(ebusy));
        chk({nm, " quotient"}, 32'(bus.quotient), 32'(eq));
        chk({nm, " remainder"}, 32'(bus.remainder), 32'(er));
        chk({nm, " dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        @(negedge clk);
        chk({nm, " done drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dn;
        int dcyc[$];
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset quotient", 32'(bus.quotient), 32'd0);
        chk("reset remainder", 32'(bus.remainder), 32'd0);
        rst_n = 1'b1;

        run(8'd200, 8'd7,   8'd28,  8'd4, 9, 8, 1'b0, "200/7");
        run(8'd255, 8'd1,   8'd255, 8'd0, 9, 8, 1'b0, "255/1");
        run(8'd5,   8'd9,   8'd0,   8'd5, 9, 8, 1'b0, "5/9");
        run(8'd255, 8'd255, 8'd1,   8'd0, 9, 8, 1'b0, "255/255");
        if (DBZ) run(8'h5A, 8'd0, 8'hFF, 8'h5A, 1, 0, 1'b1, "5A/0");
        else     run(8'h5A, 8'd0, 8'hFF, 8'h5A, 9, 8, 1'b0, "5A/0");
        run(8'd13, 8'd13, 8'd1, 8'd0, 9, 8, 1'b0, "13/13 clears dbz");

        // Second request mid-run with changed operands must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd3;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(negedge clk); bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 12 && dn == 0; i++) begin
            @(negedge clk);
            if (bus.done) dn = 1;
        end
        chk("ignore done seen", 32'(dn), 32'd1);
        chk("ignore quotient", 32'(bus.quotient), 32'd33);
        chk("ignore remainder", 32'(bus.remainder), 32'd1);
        repeat (3) @(negedge clk);

        // Reset mid-run: operation discarded, no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst quotient", 32'(bus.quotient), 32'd0);
        chk("midrst remainder", 32'(bus.remainder), 32'd0);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("midrst no done", 32'(dn), 32'd0);
        run(8'd9, 8'd2, 8'd4, 8'd1, 9, 8, 1'b0, "9/2 after reset");

        // Continuous start: re-launch every WIDTH+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd17; bus.divisor = 8'd4;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dcyc.push_back(i);
                chk("hold quotient", 32'(bus.quotient), 32'd4);
                chk("hold remainder", 32'(bus.remainder), 32'd1);
            end
        end
        bus.start = 1'b0;
        chk("hold pulse count", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            chk("hold first done", 32'(dcyc[0]), 32'd9);
            chk("hold spacing 1", 32'(dcyc[1] - dcyc[0]), 32'd10);
            chk("hold spacing 2", 32'(dcyc[2] - dcyc[1]), 32'd10);
        end
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
